l2_port_scheduler: RTL

- Shares the single lower-level memory port (ce/rw/RDY handshake, 64-bit data, 24-bit address) between two L1 cache controllers.
- Each requester owns a one-entry request slot.
- An FSM grants the port one transaction at a time.
  - Priority (pro_x) requests win over normal ones.
  - Round-robin breaks ties.
  - A streak limit prevents priority starvation.
- Sits between the two L1 caches and the L2/memory; replaces ad-hoc queueing with a fully synchronous, reset-safe sequencer.

---
 rtl/l2_pkg.sv | 25 ++
 rtl/l2_port_scheduler_req_slot.sv | 34 +++
 rtl/l2_port_scheduler.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_pkg.sv
// Shared types and constants for the two-requester L2 port scheduler.
package l2_pkg;

  localparam int unsigned L2_ADDR_W = 24;
  localparam int unsigned L2_DATA_W = 64;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRel
  } state_e;

  typedef logic req_id_t;
  localparam req_id_t ReqId1 = 1'b0;
  localparam req_id_t ReqId2 = 1'b1;

  // Field widths follow the package defaults; the top is expected to keep them.
  typedef struct packed {
    logic [L2_ADDR_W-1:0] addr;
    logic [L2_DATA_W-1:0] data;
    logic                 rw;
    logic                 pro;
  } slot_t;

endpackage

// File: rtl/l2_port_scheduler_req_slot.sv
// One-entry request slot: latches a request when empty and emptied by the scheduler.
module req_slot
  import l2_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_ce,
  input  logic  i_rdy,
  input  logic  i_clr,
  input  slot_t i_req,
  output logic  o_full,
  output slot_t o_slot
);

  logic  r_full;
  slot_t r_slot;

  // A still-high ce in the completion cycle is the finished request, not a new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_slot <= '0;
    end else if (i_clr) begin
      r_full <= 1'b0;
    end else if (i_ce && !r_full && !i_rdy) begin
      r_full <= 1'b1;
      r_slot <= i_req;
    end
  end

  assign o_full = r_full;
  assign o_slot = r_slot;

endmodule

// File: rtl/l2_port_scheduler.sv
// Arbitrates one lower-level memory port between two L1 requesters with priority,
// round-robin tie-break, a priority streak limit and an optional REQ timeout.
module l2_port_scheduler
  import l2_pkg::*;
#(
  parameter int unsigned ADDR_W         = L2_ADDR_W,
  parameter int unsigned DATA_W         = L2_DATA_W,
  parameter int unsigned MAX_PRO_STREAK = 4,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce_1,
  input  logic              ce_2,
  input  logic              rw_1,
  input  logic              rw_2,
  input  logic              pro_1,
  input  logic              pro_2,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [ADDR_W-1:0] addr_2,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  output logic [DATA_W-1:0] data_out_1,
  output logic [DATA_W-1:0] data_out_2,
  output logic              RDY_1,
  output logic              RDY_2,
  output logic              err_1,
  output logic              err_2,
  output logic [ADDR_W-1:0] addr_low,
  output logic              rw_low,
  output logic              ce_low,
  input  logic              RDY_low,
  inout  wire  [DATA_W-1:0] data_low
);

  localparam int unsigned CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned StreakW = (MAX_PRO_STREAK > 0) ? $clog2(MAX_PRO_STREAK + 1) : 1;

  state_e              r_state;
  state_e              w_state_d;
  req_id_t             r_win;
  req_id_t             r_rr;
  req_id_t             r_prev;
  logic                r_win_pro;
  logic [StreakW-1:0]  r_streak;
  logic [CntW-1:0]     r_cnt;
  logic                r_tmo;
  logic                r_ce_low;
  logic                r_rw_low;
  logic [ADDR_W-1:0]   r_addr_low;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_dout_1;
  logic [DATA_W-1:0]   r_dout_2;
  logic                r_rdy_1;
  logic                r_rdy_2;
  logic                r_err_1;
  logic                r_err_2;

  slot_t               w_req_1;
  slot_t               w_req_2;
  slot_t               w_slot_1;
  slot_t               w_slot_2;
  slot_t               w_sel;
  logic                w_full_1;
  logic                w_full_2;
  logic                w_clr_1;
  logic                w_clr_2;
  logic                w_pro_1;
  logic                w_pro_2;
  req_id_t             w_pick;
  logic                w_grant;
  logic                w_ack;
  logic                w_tmo;
  logic                w_fin;
  logic                w_tmo_hit;

  assign w_req_1 = '{addr: addr_1, data: data_in_1, rw: rw_1, pro: pro_1};
  assign w_req_2 = '{addr: addr_2, data: data_in_2, rw: rw_2, pro: pro_2};

  assign w_clr_1 = w_fin && (r_win == ReqId1);
  assign w_clr_2 = w_fin && (r_win == ReqId2);

  req_slot u_slot_1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_ce   (ce_1),
    .i_rdy  (r_rdy_1),
    .i_clr  (w_clr_1),
    .i_req  (w_req_1),
    .o_full (w_full_1),
    .o_slot (w_slot_1)
  );

  req_slot u_slot_2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_ce   (ce_2),
    .i_rdy  (r_rdy_2),
    .i_clr  (w_clr_2),
    .i_req  (w_req_2),
    .o_full (w_full_2),
    .o_slot (w_slot_2)
  );

  assign w_pro_1 = w_full_1 && w_slot_1.pro;
  assign w_pro_2 = w_full_2 && w_slot_2.pro;

  // The streak guard only yields when the pro requester is the one holding the streak.
  always_comb begin
    w_pick = r_rr;
    if (w_pro_1 ^ w_pro_2) begin
      w_pick = w_pro_1 ? ReqId1 : ReqId2;
      if ((r_streak == StreakW'(MAX_PRO_STREAK)) && (r_prev == w_pick) &&
          ((w_pick == ReqId1) ? w_full_2 : w_full_1)) begin
        w_pick = ~w_pick;
      end
    end else if (w_full_1 && !w_full_2) begin
      w_pick = ReqId1;
    end else if (w_full_2 && !w_full_1) begin
      w_pick = ReqId2;
    end
  end

  assign w_sel     = (w_pick == ReqId1) ? w_slot_1 : w_slot_2;
  assign w_tmo_hit = (TIMEOUT != 0) && (r_cnt == CntW'(TIMEOUT - 1));

  always_comb begin
    w_state_d = r_state;
    w_grant   = 1'b0;
    w_ack     = 1'b0;
    w_tmo     = 1'b0;
    w_fin     = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_full_1 || w_full_2) begin
          w_grant   = 1'b1;
          w_state_d = StReq;
        end
      end
      StReq: begin
        if (RDY_low) begin
          w_ack     = 1'b1;
          w_state_d = StRel;
        end else if (w_tmo_hit) begin
          w_tmo     = 1'b1;
          w_state_d = StRel;
        end
      end
      StRel: begin
        if (!RDY_low) begin
          w_fin     = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_win      <= ReqId1;
      r_rr       <= ReqId1;
      r_prev     <= ReqId1;
      r_win_pro  <= 1'b0;
      r_streak   <= '0;
      r_cnt      <= '0;
      r_tmo      <= 1'b0;
      r_ce_low   <= 1'b0;
      r_rw_low   <= 1'b0;
      r_addr_low <= '0;
      r_wdata    <= '0;
      r_dout_1   <= '0;
      r_dout_2   <= '0;
      r_rdy_1    <= 1'b0;
      r_rdy_2    <= 1'b0;
      r_err_1    <= 1'b0;
      r_err_2    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_rdy_1 <= 1'b0;
      r_rdy_2 <= 1'b0;
      r_err_1 <= 1'b0;
      r_err_2 <= 1'b0;
      if (r_state == StReq) begin
        r_cnt <= r_cnt + CntW'(1);
      end
      if (w_grant) begin
        r_win      <= w_pick;
        r_win_pro  <= w_sel.pro;
        r_ce_low   <= 1'b1;
        r_addr_low <= w_sel.addr;
        r_rw_low   <= w_sel.rw;
        r_wdata    <= w_sel.data;
        r_cnt      <= '0;
        r_tmo      <= 1'b0;
      end
      if (w_ack) begin
        r_ce_low <= 1'b0;
        if (r_rw_low) begin
          if (r_win == ReqId1) r_dout_1 <= data_low;
          else                 r_dout_2 <= data_low;
        end
      end
      if (w_tmo) begin
        r_ce_low <= 1'b0;
        r_tmo    <= 1'b1;
      end
      if (w_fin) begin
        if (r_win == ReqId1) begin
          r_rdy_1 <= 1'b1;
          r_err_1 <= r_tmo;
        end else begin
          r_rdy_2 <= 1'b1;
          r_err_2 <= r_tmo;
        end
        r_rr   <= ~r_win;
        r_prev <= r_win;
        if (!r_win_pro) begin
          r_streak <= '0;
        end else if (r_win != r_prev) begin
          r_streak <= StreakW'(1);
        end else if (r_streak != StreakW'(MAX_PRO_STREAK)) begin
          r_streak <= r_streak + StreakW'(1);
        end
      end
    end
  end

  assign data_low   = (r_ce_low && !r_rw_low) ? r_wdata : {DATA_W{1'bz}};
  assign ce_low     = r_ce_low;
  assign rw_low     = r_rw_low;
  assign addr_low   = r_addr_low;
  assign data_out_1 = r_dout_1;
  assign data_out_2 = r_dout_2;
  assign RDY_1      = r_rdy_1;
  assign RDY_2      = r_rdy_2;
  assign err_1      = r_err_1;
  assign err_2      = r_err_2;

endmodule
